// File: rtl/capture_buffer.sv
`default_nettype none

// ============================================================================
//  Module      : capture_buffer
//  Description : Circular trigger-capture buffer. After an arm pulse, valid
//                samples are written into a DEPTH-entry ring. A trigger
//                sample (accepted only while filling) freezes the capture
//                after post_count further samples. Reads are presented in
//                logical order (index 0 = oldest stored sample) with one
//                cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  trigger,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic                  primed,
    output logic [ADDR_WIDTH-1:0] trig_index,
    output logic [ADDR_WIDTH:0]   sample_count
);

    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   waddr_q,     waddr_d;
    logic                    primed_q,    primed_d;
    logic                    triggered_q, triggered_d;
    logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0]   post_cnt_q,  post_cnt_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    logic                    w_wr_en;
    logic [ADDR_WIDTH-1:0]   w_start_addr;
    logic [ADDR_WIDTH-1:0]   w_rd_phys;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Next-state logic: arm overrides everything, and only FILL/POST accept samples
    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        primed_d    = primed_q;
        triggered_d = triggered_q;
        trig_addr_d = trig_addr_q;
        post_cnt_d  = post_cnt_q;
        w_wr_en     = 1'b0;

        if (arm) begin
            // The sample presented alongside arm is dropped on purpose.
            state_d     = ST_FILL;
            waddr_d     = '0;
            primed_d    = 1'b0;
            triggered_d = 1'b0;
            post_cnt_d  = post_count;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (sample_valid) begin
                        w_wr_en = 1'b1;
                        waddr_d = waddr_q + ADDR_WIDTH'(1);
                        if (waddr_q == LAST_ADDR) begin
                            primed_d = 1'b1;
                        end
                        if (trigger) begin
                            triggered_d = 1'b1;
                            trig_addr_d = waddr_q;
                            state_d     = (post_cnt_q == '0) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (sample_valid) begin
                        w_wr_en    = 1'b1;
                        waddr_d    = waddr_q + ADDR_WIDTH'(1);
                        post_cnt_d = post_cnt_q - ADDR_WIDTH'(1);
                        if (waddr_q == LAST_ADDR) begin
                            primed_d = 1'b1;
                        end
                        // Counter holds the writes still owed; the last one closes the capture.
                        if (post_cnt_q == ADDR_WIDTH'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            waddr_q     <= '0;
            primed_q    <= 1'b0;
            triggered_q <= 1'b0;
            trig_addr_q <= '0;
            post_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            primed_q    <= primed_d;
            triggered_q <= triggered_d;
            trig_addr_q <= trig_addr_d;
            post_cnt_q  <= post_cnt_d;
        end
    end

    // Sample storage; reset blocks writes but never clears contents
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            mem[waddr_q] <= data;
        end
    end

    // Once the ring has wrapped, the oldest sample sits at the write pointer.
    assign w_start_addr = primed_q ? waddr_q : '0;
    assign w_rd_phys    = w_start_addr + rd_addr;

    // Registered logical-order read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[w_rd_phys];
        end
    end

    assign rd_data      = rd_data_q;
    assign busy         = (state_q == ST_FILL) || (state_q == ST_POST);
    assign done         = (state_q == ST_DONE);
    assign triggered    = triggered_q;
    assign primed       = primed_q;
    assign trig_index   = trig_addr_q - w_start_addr;
    assign sample_count = primed_q ? (ADDR_WIDTH+1)'(DEPTH) : {1'b0, waddr_q};

endmodule

`default_nettype wire

// File: tb/tb_capture_buffer.sv
`default_nettype none

// ============================================================================
//  Module      : tb_capture_buffer
//  Description : Scoreboard bench for capture_buffer. Stimulus pushes
//                expected status/read values into queues; a monitor pops
//                and compares them when the corresponding output is due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_buffer;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          trigger = 1'b0;
    logic [AW-1:0] post_count = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          triggered;
    logic          done;
    logic          primed;
    logic [AW-1:0] trig_index;
    logic [AW:0]   sample_count;

    always #5 clk = ~clk;

    capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .sample_valid (sample_valid),
        .data         (data),
        .trigger      (trigger),
        .post_count   (post_count),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .primed       (primed),
        .trig_index   (trig_index),
        .sample_count (sample_count)
    );

    typedef enum int {K_BUSY, K_DONE, K_TRIG, K_PRIMED, K_TIDX, K_SCNT} kind_t;
    typedef struct { string name; kind_t kind; logic [31:0] exp; } st_item_t;
    typedef struct { string name; logic [31:0] exp; } rd_item_t;

    st_item_t st_q[$];
    rd_item_t rd_q[$];
    logic     st_req = 1'b0;
    logic     rd_req = 1'b0;
    logic     rd_vld = 1'b0;
    int       n_cmp = 0;
    int       n_err = 0;

    function automatic logic [31:0] actual(input kind_t k);
        case (k)
            K_BUSY:   return {31'b0, busy};
            K_DONE:   return {31'b0, done};
            K_TRIG:   return {31'b0, triggered};
            K_PRIMED: return {31'b0, primed};
            K_TIDX:   return {28'b0, trig_index};
            default:  return {27'b0, sample_count};
        endcase
    endfunction

    // Read data is due one cycle after the request was presented.
    always @(posedge clk) rd_vld <= rd_req;

    // Monitor: compare on the falling edge, away from the active edge
    always @(negedge clk) begin : monitor
        rd_item_t    r;
        st_item_t    s;
        logic [31:0] a;
        if (rd_vld) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_underflow: read data %0h with nothing expected", rd_data);
            end else begin
                r = rd_q.pop_front();
                if ({24'b0, rd_data} !== r.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0h expected %0h", r.name, rd_data, r.exp);
                end
            end
        end
        if (st_req) begin
            while (st_q.size() > 0) begin
                s = st_q.pop_front();
                a = actual(s.kind);
                n_cmp++;
                if (a !== s.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0h expected %0h", s.name, a, s.exp);
                end
            end
        end
    end

    // Advance one cycle, then return all pulse inputs to idle
    task automatic tick();
        @(posedge clk);
        #1;
        reset        = 1'b0;
        arm          = 1'b0;
        sample_valid = 1'b0;
        trigger      = 1'b0;
        st_req       = 1'b0;
        rd_req       = 1'b0;
    endtask

    task automatic do_arm(input logic [AW-1:0] pc);
        arm        = 1'b1;
        post_count = pc;
        tick();
    endtask

    task automatic smp(input logic [DW-1:0] d, input logic t);
        sample_valid = 1'b1;
        data         = d;
        trigger      = t;
        tick();
    endtask

    // Queue a status expectation checked against the state in the current cycle
    task automatic chk(input string n, input kind_t k, input logic [31:0] e);
        st_q.push_back('{name: n, kind: k, exp: e});
        st_req = 1'b1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input string n);
        rd_q.push_back('{name: n, exp: {24'b0, e}});
        rd_addr = a;
        rd_req  = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state; read data is forced to zero while reset is held
        reset = 1'b1;
        tick();
        reset = 1'b1;
        rd(4'd0, 8'h00, "rst_rd_data");
        chk("rst_busy", K_BUSY, 0);
        chk("rst_done", K_DONE, 0);
        chk("rst_trig", K_TRIG, 0);
        chk("rst_primed", K_PRIMED, 0);
        chk("rst_scnt", K_SCNT, 0);
        chk("rst_tidx", K_TIDX, 0);
        tick();

        // Short capture: trigger on sample 4, three post samples
        do_arm(4'd3);
        for (int v = 0; v < 8; v++) begin
            if (v == 3) begin
                chk("t1_busy", K_BUSY, 1);
                chk("t1_trig_pre", K_TRIG, 0);
            end
            if (v == 5) chk("t1_trig_post", K_TRIG, 1);
            if (v == 7) chk("t1_done_early", K_DONE, 0);
            smp(DW'(v), v == 4);
        end
        chk("t1_done", K_DONE, 1);
        chk("t1_busy_off", K_BUSY, 0);
        chk("t1_scnt", K_SCNT, 8);
        chk("t1_tidx", K_TIDX, 4);
        chk("t1_primed", K_PRIMED, 0);
        for (int i = 0; i < 8; i++) rd(AW'(i), DW'(i), "t1_rd");

        // Wrapping capture: 20 samples, trigger on 14, stray trigger on 17 ignored
        do_arm(4'd5);
        for (int v = 0; v < 20; v++) begin
            if (v == 15) chk("t2_primed_pre", K_PRIMED, 0);
            if (v == 16) chk("t2_primed_set", K_PRIMED, 1);
            if (v == 19) chk("t2_done_early", K_DONE, 0);
            smp(DW'(v), (v == 14) || (v == 17));
        end
        chk("t2_done", K_DONE, 1);
        chk("t2_primed", K_PRIMED, 1);
        chk("t2_scnt", K_SCNT, 16);
        chk("t2_tidx", K_TIDX, 10);
        rd(4'd0, 8'd4, "t2_rd0");
        rd(4'd10, 8'd14, "t2_rd10");
        rd(4'd15, 8'd19, "t2_rd15");

        // Arm from DONE, then post_count=0 with trigger on the first sample
        do_arm(4'd0);
        chk("t3_busy", K_BUSY, 1);
        chk("t3_done_off", K_DONE, 0);
        chk("t3_primed", K_PRIMED, 0);
        chk("t3_trig", K_TRIG, 0);
        chk("t3_scnt", K_SCNT, 0);
        smp(8'hA5, 1'b1);
        chk("t3_done", K_DONE, 1);
        chk("t3_scnt1", K_SCNT, 1);
        chk("t3_tidx", K_TIDX, 0);
        rd(4'd0, 8'hA5, "t3_rd0");
        rd(4'd1, 8'd17, "t3_rd1_old");

        // Trigger without sample_valid, and arm colliding with a triggered sample
        do_arm(4'd2);
        trigger = 1'b1;
        tick();
        trigger = 1'b1;
        tick();
        chk("t4_trig_nosv", K_TRIG, 0);
        chk("t4_scnt_nosv", K_SCNT, 0);
        arm = 1'b1; post_count = 4'd2;
        sample_valid = 1'b1; trigger = 1'b1; data = 8'h55;
        tick();
        chk("t4_busy", K_BUSY, 1);
        chk("t4_trig_arm", K_TRIG, 0);
        chk("t4_scnt_arm", K_SCNT, 0);
        smp(8'h10, 1'b0);
        smp(8'h11, 1'b0);
        smp(8'h12, 1'b1);
        smp(8'h13, 1'b0);
        smp(8'h14, 1'b0);
        chk("t4_done", K_DONE, 1);
        chk("t4_scnt", K_SCNT, 5);
        chk("t4_tidx", K_TIDX, 2);
        rd(4'd0, 8'h10, "t4_rd0");
        rd(4'd2, 8'h12, "t4_rd2");
        rd(4'd4, 8'h14, "t4_rd4");

        // Reset during POST, colliding with arm and a sample; memory survives
        do_arm(4'd4);
        smp(8'h30, 1'b1);
        smp(8'h31, 1'b0);
        chk("t5_busy_post", K_BUSY, 1);
        chk("t5_trig_post", K_TRIG, 1);
        tick();
        reset = 1'b1; arm = 1'b1; post_count = 4'd7;
        sample_valid = 1'b1; trigger = 1'b1; data = 8'hEE;
        tick();
        chk("t5_rst_busy", K_BUSY, 0);
        chk("t5_rst_done", K_DONE, 0);
        chk("t5_rst_trig", K_TRIG, 0);
        chk("t5_rst_primed", K_PRIMED, 0);
        chk("t5_rst_scnt", K_SCNT, 0);
        chk("t5_rst_tidx", K_TIDX, 0);
        smp(8'h77, 1'b1);
        chk("t5_idle_busy", K_BUSY, 0);
        chk("t5_idle_trig", K_TRIG, 0);
        rd(4'd0, 8'h30, "t5_old_rd0");
        rd(4'd1, 8'h31, "t5_old_rd1");
        rd(4'd2, 8'h12, "t5_old_rd2");
        do_arm(4'd1);
        smp(8'h40, 1'b1);
        smp(8'h41, 1'b0);
        chk("t5_done", K_DONE, 1);
        chk("t5_scnt", K_SCNT, 2);
        chk("t5_tidx", K_TIDX, 0);
        rd(4'd0, 8'h40, "t5_rd0");
        rd(4'd1, 8'h41, "t5_rd1");
        rd(4'd2, 8'h12, "t5_rd2_old");

        tick();
        tick();
        n_cmp++;
        if ((st_q.size() != 0) || (rd_q.size() != 0)) begin
            n_err++;
            $display("FAIL leftover: got %0d status and %0d read items pending expected 0",
                     st_q.size(), rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
